data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_if.sv | 26 ++
 rtl/data_mem_arbiter.sv | 118 +++++++++++
 tb/tb_data_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Bus between two requesters, the arbiter and a single-ported data memory.
interface data_mem_arbiter_if;
    logic        req0, req1;
    logic        we0, we1;
    logic [1:0]  size0, size1;
    logic [15:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        busy;
    logic        mem_wrEnable, mem_rdEnable;
    logic [1:0]  mem_numberOfByte;
    logic [15:0] mem_address, mem_in, mem_out;

    modport slave (
        input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_out,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_wrEnable, mem_rdEnable, mem_numberOfByte, mem_address, mem_in
    );

    modport master (
        output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1, mem_out,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_wrEnable, mem_rdEnable, mem_numberOfByte, mem_address, mem_in
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a data memory with a one-cycle registered read path.
// state   | meaning
// IDLE    | sample requests, latch winner's command
// ISSUE   | drive one memory enable for the latched command
// CAPTURE | register mem_out into the granted port's rdata
// DONE    | pulse ack of the granted port
module data_mem_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic              clk,
    input logic              reset,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t      state;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        lat_port;
    logic        last_grant;
    logic        ack0_q, ack1_q, busy_q, wr_en_q, rd_en_q;
    logic [15:0] rdata0_q, rdata1_q;

    logic        win;
    logic        win_we;
    logic [1:0]  win_size;
    logic [15:0] win_addr;
    logic [15:0] win_wdata;

    always_comb begin
        if (bus.req0 && bus.req1)
            win = FIXED_PRIO ? 1'b0 : ~last_grant;
        else
            win = bus.req1 & ~bus.req0;
        win_we    = win ? bus.we1    : bus.we0;
        win_size  = win ? bus.size1  : bus.size0;
        win_addr  = win ? bus.addr1  : bus.addr0;
        win_wdata = win ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_size   <= 2'b00;
            lat_addr   <= 16'h0000;
            lat_wdata  <= 16'h0000;
            lat_port   <= 1'b0;
            last_grant <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rdata0_q   <= 16'h0000;
            rdata1_q   <= 16'h0000;
        end else begin
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        lat_we     <= win_we;
                        lat_size   <= win_size;
                        lat_addr   <= win_addr;
                        lat_wdata  <= win_wdata;
                        lat_port   <= win;
                        last_grant <= win;
                        wr_en_q    <= win_we;
                        rd_en_q    <= ~win_we;
                        busy_q     <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Writes skip CAPTURE; ack is registered on entry to DONE.
                    if (lat_we) begin
                        ack0_q <= ~lat_port;
                        ack1_q <= lat_port;
                        state  <= DONE;
                    end else begin
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (lat_port)
                        rdata1_q <= bus.mem_out;
                    else
                        rdata0_q <= bus.mem_out;
                    ack0_q <= ~lat_port;
                    ack1_q <= lat_port;
                    state  <= DONE;
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ack0             = ack0_q;
    assign bus.ack1             = ack1_q;
    assign bus.rdata0           = rdata0_q;
    assign bus.rdata1           = rdata1_q;
    assign bus.busy             = busy_q;
    assign bus.mem_wrEnable     = wr_en_q;
    assign bus.mem_rdEnable     = rd_en_q;
    // The memory has no meaning for code 11, so it is sent as a 16-bit access.
    assign bus.mem_numberOfByte = (lat_size == 2'b11) ? 2'b00 : lat_size;
    assign bus.mem_address      = lat_addr;
    assign bus.mem_in           = lat_wdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios, then random rounds checked against a transaction-level model.
module tb_data_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic fp_en = 1'b0;
    logic        pre_we = 1'b0;
    logic [15:0] pre_addr = 16'h0;
    logic [7:0]  pre_data = 8'h0;

    data_mem_arbiter_if bus_a ();
    data_mem_arbiter_if bus_b ();

    data_mem_arbiter #(.FIXED_PRIO(1'b0)) dut_rr (.clk(clk), .reset(reset), .bus(bus_a));
    data_mem_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    assign bus_b.req0   = fp_en & bus_a.req0;
    assign bus_b.req1   = fp_en & bus_a.req1;
    assign bus_b.we0    = bus_a.we0;
    assign bus_b.we1    = bus_a.we1;
    assign bus_b.size0  = bus_a.size0;
    assign bus_b.size1  = bus_a.size1;
    assign bus_b.addr0  = bus_a.addr0;
    assign bus_b.addr1  = bus_a.addr1;
    assign bus_b.wdata0 = bus_a.wdata0;
    assign bus_b.wdata1 = bus_a.wdata1;

    // Behavioural data memories (one per DUT), read data registered.
    logic [7:0] mem_a [0:65535];
    logic [7:0] mem_b [0:65535];

    function automatic logic [15:0] dev_read(input logic [1:0] nob, input logic [7:0] lo, input logic [7:0] hi);
        case (nob)
            2'b01:   return {8'h00, lo};
            2'b10:   return {{8{lo[7]}}, lo};
            default: return {hi, lo};
        endcase
    endfunction

    always @(posedge clk) begin
        if (pre_we) begin
            mem_a[pre_addr] <= pre_data;
            mem_b[pre_addr] <= pre_data;
        end
        if (bus_a.mem_wrEnable) begin
            mem_a[bus_a.mem_address] <= bus_a.mem_in[7:0];
            if (bus_a.mem_numberOfByte == 2'b00)
                mem_a[bus_a.mem_address + 16'd1] <= bus_a.mem_in[15:8];
        end
        if (bus_a.mem_rdEnable)
            bus_a.mem_out <= dev_read(bus_a.mem_numberOfByte, mem_a[bus_a.mem_address],
                                      mem_a[bus_a.mem_address + 16'd1]);
        if (bus_b.mem_wrEnable) begin
            mem_b[bus_b.mem_address] <= bus_b.mem_in[7:0];
            if (bus_b.mem_numberOfByte == 2'b00)
                mem_b[bus_b.mem_address + 16'd1] <= bus_b.mem_in[15:8];
        end
        if (bus_b.mem_rdEnable)
            bus_b.mem_out <= dev_read(bus_b.mem_numberOfByte, mem_b[bus_b.mem_address],
                                      mem_b[bus_b.mem_address + 16'd1]);
    end

    // Reference model state: byte image, last grant, expected rdata per port.
    typedef struct {
        bit          we;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [15:0] wdata;
    } op_t;

    logic [7:0]  ref_mem [0:65535];
    op_t         op [2];
    int          model_last = 1;
    logic [15:0] exp_rd [2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [15:0] ref_read(input op_t o);
        logic [7:0] lo, hi;
        lo = ref_mem[o.addr];
        hi = ref_mem[16'(o.addr + 16'd1)];
        if (o.size == 2'd1) return {8'h00, lo};
        if (o.size == 2'd2) return {{8{lo[7]}}, lo};
        return {hi, lo};
    endfunction

    task automatic ref_write(input op_t o);
        ref_mem[o.addr] = o.wdata[7:0];
        if (o.size == 2'd0 || o.size == 2'd3)
            ref_mem[16'(o.addr + 16'd1)] = o.wdata[15:8];
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
    endtask

    task automatic set_port(input int p);
        if (p == 0) begin
            bus_a.we0 = op[0].we; bus_a.size0 = op[0].size;
            bus_a.addr0 = op[0].addr; bus_a.wdata0 = op[0].wdata;
        end else begin
            bus_a.we1 = op[1].we; bus_a.size1 = op[1].size;
            bus_a.addr1 = op[1].addr; bus_a.wdata1 = op[1].wdata;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus_a.busy !== 1'b0 && k < 12) begin
            @(negedge clk);
            k++;
        end
        if (bus_a.busy !== 1'b0) chk("idle_timeout", 16'(bus_a.busy), 16'd0);
    endtask

    // One round on the round-robin DUT; cycle 0 is the IDLE cycle that samples req.
    task automatic run_round(input bit m0, input bit m1, input bit early);
        int  first, second, limit, ip;
        int  t_iss [2];
        int  t_ack [2];
        bit  both, iss_wr, iss_rd, busy_e;
        both = m0 && m1;
        t_iss[0] = -5; t_iss[1] = -5; t_ack[0] = -5; t_ack[1] = -5;
        if (both) first = (model_last == 0) ? 1 : 0;
        else      first = m1 ? 1 : 0;
        second = 1 - first;
        t_iss[first] = 1;
        t_ack[first] = op[first].we ? 2 : 3;
        limit = t_ack[first];
        model_last = first;
        if (both) begin
            t_iss[second] = t_ack[first] + 2;
            t_ack[second] = t_iss[second] + (op[second].we ? 1 : 2);
            limit = t_ack[second];
            model_last = second;
        end
        wait_idle();
        set_port(0);
        set_port(1);
        bus_a.req0 = m0;
        bus_a.req1 = m1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            ip = -1;
            if (c == t_iss[first]) ip = first;
            else if (both && c == t_iss[second]) ip = second;
            iss_wr = 1'b0;
            iss_rd = 1'b0;
            if (ip >= 0) begin
                iss_wr = op[ip].we;
                iss_rd = !op[ip].we;
                chk("mem_address", bus_a.mem_address, op[ip].addr);
                chk("mem_nob", 16'(bus_a.mem_numberOfByte), 16'((op[ip].size == 2'd3) ? 2'd0 : op[ip].size));
                if (op[ip].we) chk("mem_in", bus_a.mem_in, op[ip].wdata);
            end
            chk("mem_wrEnable", 16'(bus_a.mem_wrEnable), 16'(iss_wr));
            chk("mem_rdEnable", 16'(bus_a.mem_rdEnable), 16'(iss_rd));
            busy_e = (c >= t_iss[0] && c <= t_ack[0]) || (c >= t_iss[1] && c <= t_ack[1]);
            chk("busy", 16'(bus_a.busy), 16'(busy_e));
            for (int p = 0; p < 2; p++) begin
                if (c == t_ack[p]) begin
                    if (op[p].we) ref_write(op[p]);
                    else          exp_rd[p] = ref_read(op[p]);
                    if (p == 0) bus_a.req0 = 1'b0;
                    else        bus_a.req1 = 1'b0;
                end
            end
            chk("ack0", 16'(bus_a.ack0), 16'(c == t_ack[0]));
            chk("ack1", 16'(bus_a.ack1), 16'(c == t_ack[1]));
            chk("rdata0", bus_a.rdata0, exp_rd[0]);
            chk("rdata1", bus_a.rdata1, exp_rd[1]);
            if (early && c == 1) begin
                bus_a.req0 = 1'b0;
                bus_a.req1 = 1'b0;
            end
        end
    endtask

    initial begin
        int w, pw;
        bit m0, m1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        bus_a.req0 = 0; bus_a.req1 = 0; bus_a.we0 = 0; bus_a.we1 = 0;
        bus_a.size0 = 0; bus_a.size1 = 0; bus_a.addr0 = 0; bus_a.addr1 = 0;
        bus_a.wdata0 = 0; bus_a.wdata1 = 0;

        for (int i = 0; i < 32; i++)
            preload(16'(i), (i == 1) ? 8'h01 : (i == 2) ? 8'h02 : 8'(i * 8'h13 + 8'h5B));
        preload(16'hFFFF, 8'hA7);
        @(negedge clk);
        pre_we = 1'b0;

        chk("rst_busy", 16'(bus_a.busy), 16'd0);
        chk("rst_ack", 16'({bus_a.ack1, bus_a.ack0}), 16'd0);
        chk("rst_en", 16'({bus_a.mem_wrEnable, bus_a.mem_rdEnable}), 16'd0);
        chk("rst_rdata0", bus_a.rdata0, 16'h0);
        chk("rst_rdata1", bus_a.rdata1, 16'h0);
        chk("rst_addr", bus_a.mem_address, 16'h0);
        reset = 1'b0;

        op[0] = '{we: 1'b0, size: 2'd0, addr: 16'h0001, wdata: 16'h0};
        run_round(1'b1, 1'b0, 1'b0);
        chk("rd0_0201", bus_a.rdata0, 16'h0201);

        op[1] = '{we: 1'b1, size: 2'd0, addr: 16'h0010, wdata: 16'hBEEF};
        run_round(1'b0, 1'b1, 1'b0);
        chk("rd0_kept", bus_a.rdata0, 16'h0201);
        op[1] = '{we: 1'b0, size: 2'd1, addr: 16'h0010, wdata: 16'h0};
        run_round(1'b0, 1'b1, 1'b0);
        chk("rd1_zext", bus_a.rdata1, 16'h00EF);
        op[1] = '{we: 1'b0, size: 2'd2, addr: 16'h0010, wdata: 16'h0};
        run_round(1'b0, 1'b1, 1'b0);
        chk("rd1_sext", bus_a.rdata1, 16'hFFEF);

        op[0] = '{we: 1'b0, size: 2'd3, addr: 16'h0002, wdata: 16'h0};
        run_round(1'b1, 1'b0, 1'b0);

        // Contention: both reads held high on both DUTs for four grants.
        wait_idle();
        op[0] = '{we: 1'b0, size: 2'd0, addr: 16'h0001, wdata: 16'h0};
        op[1] = '{we: 1'b0, size: 2'd1, addr: 16'h0010, wdata: 16'h0};
        set_port(0);
        set_port(1);
        fp_en = 1'b1;
        bus_a.req0 = 1'b1;
        bus_a.req1 = 1'b1;
        w = (model_last == 1) ? 0 : 1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            pw = -1;
            if (c % 4 == 3) begin
                pw = w ^ ((c / 4) & 1);
                exp_rd[pw] = ref_read(op[pw]);
                model_last = pw;
            end
            chk("cont_ack0", 16'(bus_a.ack0), 16'(pw == 0));
            chk("cont_ack1", 16'(bus_a.ack1), 16'(pw == 1));
            chk("cont_rdata0", bus_a.rdata0, exp_rd[0]);
            chk("cont_rdata1", bus_a.rdata1, exp_rd[1]);
            chk("fp_ack0", 16'(bus_b.ack0), 16'(c % 4 == 3));
            chk("fp_ack1", 16'(bus_b.ack1), 16'd0);
        end
        bus_a.req0 = 1'b0;
        bus_a.req1 = 1'b0;
        fp_en = 1'b0;

        // Reset during the ISSUE cycle of a write.
        wait_idle();
        op[0] = '{we: 1'b1, size: 2'd0, addr: 16'h0005, wdata: 16'h1234};
        set_port(0);
        bus_a.req0 = 1'b1;
        @(negedge clk);
        chk("pre_rst_wr", 16'(bus_a.mem_wrEnable), 16'd1);
        #1 reset = 1'b1;
        #1;
        chk("rst_wr_drop", 16'(bus_a.mem_wrEnable), 16'd0);
        chk("rst_rd_drop", 16'(bus_a.mem_rdEnable), 16'd0);
        chk("rst_busy_drop", 16'(bus_a.busy), 16'd0);
        chk("rst_rdata0_clr", bus_a.rdata0, 16'h0);
        bus_a.req0 = 1'b0;
        @(negedge clk);
        chk("rst_no_ack", 16'({bus_a.ack1, bus_a.ack0}), 16'd0);
        chk("rst_no_en", 16'({bus_a.mem_wrEnable, bus_a.mem_rdEnable}), 16'd0);
        reset = 1'b0;
        model_last = 1;
        exp_rd[0] = 16'h0;
        exp_rd[1] = 16'h0;
        op[0] = '{we: 1'b0, size: 2'd0, addr: 16'h0005, wdata: 16'h0};
        run_round(1'b1, 1'b0, 1'b0);

        // Random rounds, including contention, wrap addresses and early req drops.
        for (int r = 0; r < 40; r++) begin
            for (int p = 0; p < 2; p++) begin
                op[p].we    = 1'($urandom_range(0, 1));
                op[p].size  = 2'($urandom_range(0, 3));
                op[p].addr  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 30));
                op[p].wdata = 16'($urandom);
            end
            w  = $urandom_range(1, 3);
            m0 = (w & 1) != 0;
            m1 = (w & 2) != 0;
            run_round(m0, m1, !(m0 && m1) && ($urandom_range(0, 4) == 0));
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
